univ_shift_reg: RTL and testbench

Parametrised universal shift register: W-bit register with hold, parallel load, logical/arithmetic shifts and rotates in both directions, plus an autonomous burst mode that shifts a programmed number of positions under an FSM with busy/done handshake. It is the general-width successor to the team's 8-bit hold/load/shift register. It serves as the serialiser/deserialiser and barrel-free multi-position shifter for later datapath labs.

---
 rtl/univ_shift_reg_pkg.sv | 65 ++++++
 rtl/univ_shift_reg_cell.sv | 29 ++
 rtl/univ_shift_reg.sv | 124 ++++++++++++
 tb/tb_univ_shift_reg.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
// Maps an operation onto per-cell mux selects.
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      HOLD, SHU, SHD, LOAD, ROU, ROD, ASR, RSV
   } op_e;

   typedef enum logic [1:0] {
      IDLE, SHIFT, DONE
   } state_e;

   // Which input a cell takes: itself, its lower
   // neighbour, its upper neighbour or load data.
   typedef enum logic [1:0] {
      SEL_HOLD, SEL_UP, SEL_DN, SEL_LOAD
   } sel_e;

   // Source of the bit entering at the open end.
   typedef enum logic [1:0] {
      FILL_I, FILL_MSB, FILL_LSB
   } fill_e;

   typedef struct packed {
      sel_e  sel;
      fill_e fill;
      logic  so_en;
   } step_t;

   function automatic step_t step_of(op_e op);
      step_t s;
      s.sel   = SEL_HOLD;
      s.fill  = FILL_I;
      s.so_en = 1'b0;
      case (op)
         SHU: begin
            s.sel   = SEL_UP;
            s.so_en = 1'b1;
         end
         SHD: begin
            s.sel   = SEL_DN;
            s.so_en = 1'b1;
         end
         LOAD: s.sel = SEL_LOAD;
         ROU: begin
            s.sel   = SEL_UP;
            s.fill  = FILL_MSB;
            s.so_en = 1'b1;
         end
         ROD: begin
            s.sel   = SEL_DN;
            s.fill  = FILL_LSB;
            s.so_en = 1'b1;
         end
         ASR: begin
            s.sel   = SEL_DN;
            s.fill  = FILL_MSB;
            s.so_en = 1'b1;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/univ_shift_reg_cell.sv
// One register bit: neighbour-select mux plus flop.
// Instantiated once per bit by the top level.
module shift_cell
   import univ_shift_reg_pkg::*;
(
   input  logic c,
   input  logic nrst,
   input  sel_e sel,
   input  logic lo,
   input  logic hi,
   input  logic d,
   output logic q
);

   // Select the next bit value and register it
   always_ff @(posedge c) begin
      if (!nrst) begin
         q <= 1'b0;
      end else begin
         case (sel)
            SEL_UP:   q <= lo;
            SEL_DN:   q <= hi;
            SEL_LOAD: q <= d;
            default:  q <= q;
         endcase
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops
// and an FSM-driven multi-position burst shift.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          c,
   input  logic          nrst,
   input  logic [2:0]    op,
   input  logic [W-1:0]  d,
   input  logic          i,
   input  logic          start,
   input  logic          dir,
   input  logic [CW-1:0] amt,
   output logic [W-1:0]  q,
   output logic          so,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] WMAX = CW'(W);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_e        state;
   logic [CW-1:0] cnt;
   logic          dir_r;
   logic [CW-1:0] amt_sat;
   step_t         st;
   logic          fill;
   logic          so_val;

   assign amt_sat = (amt > WMAX) ? WMAX : amt;

   // Pick this cycle's step: burst, start (no shift) or op
   always_comb begin
      st = step_of(HOLD);
      if (state == SHIFT) begin
         st = step_of(dir_r ? SHD : SHU);
      end else if (!start) begin
         st = step_of(op_e'(op));
      end
      fill = i;
      if (st.fill == FILL_MSB) fill = q[W-1];
      if (st.fill == FILL_LSB) fill = q[0];
      so_val = (st.sel == SEL_UP) ? q[W-1] : q[0];
   end

   for (genvar g = 0; g < W; g++) begin : g_bit
      logic lo;
      logic hi;
      if (g == 0) begin : g_lo
         assign lo = fill;
      end else begin : g_lo
         assign lo = q[g-1];
      end
      if (g == W - 1) begin : g_hi
         assign hi = fill;
      end else begin : g_hi
         assign hi = q[g+1];
      end
      shift_cell u_cell (
         .c    (c),
         .nrst (nrst),
         .sel  (st.sel),
         .lo   (lo),
         .hi   (hi),
         .d    (d[g]),
         .q    (q[g])
      );
   end

   // Serial out captures the bit leaving the register
   always_ff @(posedge c) begin
      if (!nrst) begin
         so <= 1'b0;
      end else if (st.so_en) begin
         so <= so_val;
      end
   end

   // Burst FSM with registered busy/done decodes
   always_ff @(posedge c) begin
      if (!nrst) begin
         state <= IDLE;
         cnt   <= '0;
         dir_r <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            SHIFT: begin
               cnt <= cnt - ONE;
               if (cnt == ONE) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  dir_r <= dir;
                  cnt   <= amt_sat;
                  if (amt_sat != '0) begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised bench for univ_shift_reg (W=8 and W=16)
// against an arithmetic reference model.
module tb_univ_shift_reg;

   logic c = 1'b0;
   always #5 c = ~c;

   logic       nrst;
   logic [2:0] op;
   logic [7:0] d;
   logic       i, start, dir;
   logic [3:0] amt;
   logic [7:0] q;
   logic       so, busy, done;

   logic [2:0]  op16;
   logic [15:0] d16;
   logic        i16, start16, dir16;
   logic [4:0]  amt16;
   logic [15:0] q16;
   logic        so16, busy16, done16;

   int n_chk = 0;
   int n_fail = 0;
   int mq, mso;

   univ_shift_reg #(.W(8)) dut (
      .c(c), .nrst(nrst), .op(op), .d(d), .i(i),
      .start(start), .dir(dir), .amt(amt),
      .q(q), .so(so), .busy(busy), .done(done)
   );

   univ_shift_reg #(.W(16)) dut16 (
      .c(c), .nrst(nrst), .op(op16), .d(d16), .i(i16),
      .start(start16), .dir(dir16), .amt(amt16),
      .q(q16), .so(so16), .busy(busy16), .done(done16)
   );

   // Reference: register treated as an unsigned integer
   function automatic int nxt_q(int w, int o, int qv,
                                int b, int dv);
      int m = 1 << w;
      int t = m / 2;
      case (o)
         1: return (qv * 2 + b) % m;
         2: return qv / 2 + b * t;
         3: return dv;
         4: return (qv * 2) % m + qv / t;
         5: return qv / 2 + (qv % 2) * t;
         6: return qv / 2 + ((qv >= t) ? t : 0);
         default: return qv;
      endcase
   endfunction

   function automatic int nxt_so(int w, int o, int qv, int sv);
      int t = (1 << w) / 2;
      case (o)
         1, 4:    return qv / t;
         2, 5, 6: return qv % 2;
         default: return sv;
      endcase
   endfunction

   task automatic tick;
      @(posedge c);
      #1;
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      tick();
      tick();
      if ({q, so, busy, done} !== 11'h0) begin
         n_fail++;
         $display("FAIL reset8: got %h want 000", {q, so, busy, done});
      end
      n_chk++;
      if ({q16, so16, busy16, done16} !== 19'h0) begin
         n_fail++;
         $display("FAIL reset16: got %h want 0", {q16, so16, busy16, done16});
      end
      n_chk++;
      nrst = 1'b1;
      mq = 0;
      mso = 0;
   endtask

   task automatic test_directed_ops;
      logic [2:0] ops [4] = '{3'd3, 3'd1, 3'd5, 3'd6};
      logic [7:0] eq  [4] = '{8'hA5, 8'h4B, 8'hA5, 8'hD2};
      logic       es  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 4; k++) begin
         op = ops[k];
         d = 8'hA5;
         i = 1'b1;
         tick();
         if (q !== eq[k] || so !== es[k]) begin
            n_fail++;
            $display("FAIL dir_op%0d: got q=%h so=%b want q=%h so=%b",
                     k, q, so, eq[k], es[k]);
         end
         n_chk++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_flags%0d: busy=%b done=%b want 0 0",
                     k, busy, done);
         end
         n_chk++;
      end
      op = 3'd0;
      mq = 'hD2;
      mso = 1;
   endtask

   task automatic test_random_ops;
      for (int k = 0; k < 60; k++) begin
         op = 3'($urandom_range(0, 7));
         d = 8'($urandom);
         i = 1'($urandom);
         tick();
         mso = nxt_so(8, int'(op), mq, mso);
         mq = nxt_q(8, int'(op), mq, int'(i), int'(d));
         if (q !== mq[7:0] || so !== mso[0] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_op%0d op=%0d: got q=%h so=%b busy=%b want q=%h so=%b busy=0",
                     k, op, q, so, busy, mq[7:0], mso[0]);
         end
         n_chk++;
      end
      op = 3'd0;
   endtask

   task automatic test_burst;
      int lv, dv, av, iv, n, b;
      for (int e = 0; e < 12; e++) begin
         lv = int'($urandom_range(0, 255));
         dv = int'($urandom_range(0, 1));
         av = int'($urandom_range(0, 15));
         iv = -1;
         if (e == 0) begin lv = 'h81; dv = 1; av = 3;  iv = 0; end
         if (e == 1) begin av = 0; end
         if (e == 2) begin dv = 0; av = 15; iv = 1; end
         if (e == 3) begin dv = 1; av = 15; iv = 0; end
         op = 3'd3;
         d = 8'(lv);
         tick();
         mq = lv;
         op = 3'd0;
         start = 1'b1;
         dir = 1'(dv);
         amt = 4'(av);
         tick();
         start = 1'b0;
         n = (av > 8) ? 8 : av;
         if (busy !== (n > 0) || done !== (n == 0) || q !== mq[7:0]) begin
            n_fail++;
            $display("FAIL burst%0d_start: busy=%b done=%b q=%h want %b %b %h",
                     e, busy, done, q, n > 0, n == 0, mq[7:0]);
         end
         n_chk++;
         for (int k = 1; k <= n; k++) begin
            b = (iv >= 0) ? iv : int'($urandom_range(0, 1));
            i = 1'(b);
            tick();
            mso = nxt_so(8, dv ? 2 : 1, mq, mso);
            mq = nxt_q(8, dv ? 2 : 1, mq, b, 0);
            if (q !== mq[7:0] || so !== mso[0] ||
                busy !== (k < n) || done !== (k == n)) begin
               n_fail++;
               $display("FAIL burst%0d_edge%0d: q=%h so=%b busy=%b done=%b want %h %b %b %b",
                        e, k, q, so, busy, done, mq[7:0], mso[0], k < n, k == n);
            end
            n_chk++;
         end
         if (e == 0 && (q !== 8'h10 || so !== 1'b0)) begin
            n_fail++;
            $display("FAIL burst_81: q=%h so=%b want 10 0", q, so);
         end
         if (e == 0) n_chk++;
         if (e == 2 && q !== 8'hFF) begin
            n_fail++;
            $display("FAIL burst_sat_up: q=%h want ff", q);
         end
         if (e == 2) n_chk++;
         if (e == 3 && q !== 8'h00) begin
            n_fail++;
            $display("FAIL burst_sat_dn: q=%h want 00", q);
         end
         if (e == 3) n_chk++;
         tick();
         if (busy !== 1'b0 || done !== 1'b0 || q !== mq[7:0]) begin
            n_fail++;
            $display("FAIL burst%0d_after: busy=%b done=%b q=%h want 0 0 %h",
                     e, busy, done, q, mq[7:0]);
         end
         n_chk++;
      end
   endtask

   task automatic test_back_to_back;
      int b;
      op = 3'd3;
      d = 8'($urandom);
      tick();
      mq = int'(d);
      op = 3'd0;
      start = 1'b1;
      dir = 1'b0;
      amt = 4'd2;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         b = int'($urandom_range(0, 1));
         i = 1'(b);
         tick();
         mso = nxt_so(8, 1, mq, mso);
         mq = nxt_q(8, 1, mq, b, 0);
      end
      if (done !== 1'b1 || q !== mq[7:0]) begin
         n_fail++;
         $display("FAIL b2b_first: done=%b q=%h want 1 %h", done, q, mq[7:0]);
      end
      n_chk++;
      start = 1'b1;
      dir = 1'b1;
      amt = 4'd3;
      tick();
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || q !== mq[7:0]) begin
         n_fail++;
         $display("FAIL b2b_restart: busy=%b done=%b q=%h want 1 0 %h",
                  busy, done, q, mq[7:0]);
      end
      n_chk++;
      for (int k = 1; k <= 3; k++) begin
         b = int'($urandom_range(0, 1));
         i = 1'(b);
         tick();
         mso = nxt_so(8, 2, mq, mso);
         mq = nxt_q(8, 2, mq, b, 0);
      end
      if (done !== 1'b1 || busy !== 1'b0 || q !== mq[7:0] || so !== mso[0]) begin
         n_fail++;
         $display("FAIL b2b_second: done=%b busy=%b q=%h so=%b want 1 0 %h %b",
                  done, busy, q, so, mq[7:0], mso[0]);
      end
      n_chk++;
      tick();
   endtask

   task automatic test_ignore_mid_burst;
      int b;
      op = 3'd3;
      d = 8'($urandom);
      tick();
      mq = int'(d);
      op = 3'd0;
      start = 1'b1;
      dir = 1'b0;
      amt = 4'd4;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         b = int'($urandom_range(0, 1));
         i = 1'(b);
         op = 3'd3;
         d = ~q;
         start = 1'b1;
         dir = 1'b1;
         amt = 4'd1;
         tick();
         mso = nxt_so(8, 1, mq, mso);
         mq = nxt_q(8, 1, mq, b, 0);
         if (q !== mq[7:0] || busy !== (k < 4) || done !== (k == 4)) begin
            n_fail++;
            $display("FAIL ignore_edge%0d: q=%h busy=%b done=%b want %h %b %b",
                     k, q, busy, done, mq[7:0], k < 4, k == 4);
         end
         n_chk++;
      end
      op = 3'd0;
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_burst;
      int seen = 0;
      op = 3'd3;
      d = 8'($urandom_range(1, 255));
      tick();
      op = 3'd0;
      start = 1'b1;
      dir = 1'b0;
      amt = 4'd5;
      i = 1'b1;
      tick();
      start = 1'b0;
      tick();
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      if ({q, so, busy, done} !== 11'h0) begin
         n_fail++;
         $display("FAIL rst_mid: got %h want 000", {q, so, busy, done});
      end
      n_chk++;
      for (int k = 0; k < 8; k++) begin
         if (done || busy) seen++;
         tick();
      end
      if (seen != 0) begin
         n_fail++;
         $display("FAIL rst_mid_flags: busy/done cycles=%0d want 0", seen);
      end
      n_chk++;
      mq = 0;
      mso = 0;
   endtask

   task automatic test_w16;
      int m16 = 0, s16 = 0, cnt = 0, got_done = 0;
      op16 = 3'd3;
      d16 = 16'h8001;
      tick();
      op16 = 3'd4;
      repeat (16) tick();
      op16 = 3'd0;
      if (q16 !== 16'h8001) begin
         n_fail++;
         $display("FAIL w16_rou: q=%h want 8001", q16);
      end
      n_chk++;
      m16 = 'h8001;
      s16 = int'(so16);
      for (int k = 0; k < 20; k++) begin
         op16 = 3'($urandom_range(0, 7));
         d16 = 16'($urandom);
         i16 = 1'($urandom);
         tick();
         s16 = nxt_so(16, int'(op16), m16, s16);
         m16 = nxt_q(16, int'(op16), m16, int'(i16), int'(d16));
         if (q16 !== m16[15:0] || so16 !== s16[0]) begin
            n_fail++;
            $display("FAIL w16_op%0d op=%0d: q=%h so=%b want %h %b",
                     k, op16, q16, so16, m16[15:0], s16[0]);
         end
         n_chk++;
      end
      op16 = 3'd0;
      i16 = 1'b1;
      start16 = 1'b1;
      dir16 = 1'b0;
      amt16 = 5'd16;
      tick();
      start16 = 1'b0;
      for (int t = 0; t < 24; t++) begin
         if (done16) begin
            got_done = 1;
            break;
         end
         if (busy16) cnt++;
         tick();
      end
      if (got_done != 1 || cnt != 16 || q16 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL w16_burst: done=%0d busy_cycles=%0d q=%h want 1 16 ffff",
                  got_done, cnt, q16);
      end
      n_chk++;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      nrst = 1'b0;
      op = 3'd0; d = 8'h0; i = 1'b0;
      start = 1'b0; dir = 1'b0; amt = 4'd0;
      op16 = 3'd0; d16 = 16'h0; i16 = 1'b0;
      start16 = 1'b0; dir16 = 1'b0; amt16 = 5'd0;
      test_reset();
      test_directed_ops();
      test_random_ops();
      test_burst();
      test_back_to_back();
      test_ignore_mid_burst();
      test_reset_mid_burst();
      test_random_ops();
      test_w16();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
